// File: rtl/fft_stage_sequencer.sv
// Owns the sample buffer of one FFT_step: load SAMPLES words, run every butterfly stage, drain in index order.
// Latency: SAMPLES load beats + STAGES*(STEP_LATENCY+1) step cycles + SAMPLES drain beats; stalls on in_valid/out_ready.
// Optional FFT_SEQ_BITREV_EN: load address is bit-reversed idx (decimation-in-time input reorder happens here).
module fft_stage_sequencer #(
    parameter int SAMPLES      = 4,
    parameter int WIDTH        = 32,
    parameter int STEP_LATENCY = 1,
    localparam int STAGES      = $clog2(SAMPLES),
    localparam int SW          = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [SAMPLES*WIDTH-1:0]   step_in,
    output logic [SW-1:0]              stage_number,
    input  logic [SAMPLES*WIDTH-1:0]   step_out,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int IW = $clog2(SAMPLES);
    localparam int WW = (STEP_LATENCY > 0) ? $clog2(STEP_LATENCY + 1) : 1;

    localparam logic [IW-1:0] IDX_LAST   = IW'(SAMPLES - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(STEP_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  buffer [SAMPLES];
    logic [IW-1:0]     idx;
    logic [SW-1:0]     stage;
    logic [WW-1:0]     wait_cnt;
    logic              done_q;
    logic [IW-1:0]     load_addr;
    logic              load_fire;
    logic              drain_fire;
    logic              stage_end;
    logic              last_idx;
    logic              last_stage;

`ifdef FFT_SEQ_BITREV_EN
    function automatic logic [IW-1:0] bit_reverse(input logic [IW-1:0] a);
        logic [IW-1:0] r;
        r = '0;
        for (int b = 0; b < IW; b++) begin
            r[b] = a[IW-1-b];
        end
        return r;
    endfunction

    assign load_addr = bit_reverse(idx);
`else
    assign load_addr = idx;
`endif

    assign last_idx   = (idx == IDX_LAST);
    assign last_stage = (stage == STAGE_LAST);
    assign load_fire  = (state == S_LOAD) && in_valid;
    assign drain_fire = (state == S_DRAIN) && out_ready;
    assign stage_end  = (state == S_STEP) && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_idx) begin
                    state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                if (stage_end && last_stage) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && last_idx) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The step sees the buffer directly; it only changes at a stage boundary, so it is stable for a whole stage.
    always_comb begin
        step_in = '0;
        for (int j = 0; j < SAMPLES; j++) begin
            step_in[j*WIDTH +: WIDTH] = buffer[j];
        end
    end

    assign out_data     = (state == S_DRAIN) ? buffer[idx] : '0;
    assign stage_number = stage;
    assign busy         = (state != S_IDLE);
    assign done         = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            stage    <= '0;
            wait_cnt <= '0;
            done_q   <= 1'b0;
            for (int j = 0; j < SAMPLES; j++) begin
                buffer[j] <= '0;
            end
        end else begin
            state  <= state_nxt;
            done_q <= drain_fire && last_idx;
            case (state)
                S_IDLE: begin
                    idx      <= '0;
                    stage    <= '0;
                    wait_cnt <= '0;
                end
                S_LOAD: begin
                    if (load_fire) begin
                        buffer[load_addr] <= in_data;
                        idx               <= last_idx ? '0 : idx + IW'(1);
                    end
                end
                S_STEP: begin
                    if (stage_end) begin
                        for (int j = 0; j < SAMPLES; j++) begin
                            buffer[j] <= step_out[j*WIDTH +: WIDTH];
                        end
                        wait_cnt <= '0;
                        // Park the stage index at 0 after the last stage so a 1-stage build never shows 1.
                        stage    <= last_stage ? '0 : stage + SW'(1);
                        idx      <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_fire) begin
                        idx <= last_idx ? '0 : idx + IW'(1);
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: +1 stub step, hand-derived vector table, corner sequences, random runs vs a scatter/add model.
module tb_fft_stage_sequencer;

    localparam int N      = 4;
    localparam int W      = 32;
    localparam int LAT    = 1;
    localparam int STAGES = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] step_in;
    logic [0:0]     stage_number;
    logic [N*W-1:0] step_out = '0;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           busy;
    logic           done;

    int n_chk  = 0;
    int n_pass = 0;

    fft_stage_sequencer #(.SAMPLES(N), .WIDTH(W), .STEP_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .step_in(step_in), .stage_number(stage_number), .step_out(step_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Stub step: every word +1, one cycle of latency.
    always @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            step_out[j*W +: W] <= step_in[j*W +: W] + 32'd1;
        end
    end

    task automatic chk1(input string name, input logic act, input logic req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic chkw(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Where input beat k lands in the buffer.
    function automatic int load_pos(input int k);
        int r;
        int v;
        r = 0;
        v = k;
`ifdef FFT_SEQ_BITREV_EN
        for (int b = 0; b < $clog2(N); b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
`else
        r = v;
`endif
        return r;
    endfunction

    function automatic logic [N*W-1:0] model_buf(input logic [N*W-1:0] din);
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[load_pos(k)*W +: W] = din[k*W +: W];
        return r;
    endfunction

    function automatic logic [N*W-1:0] model_out(input logic [N*W-1:0] din);
        logic [N*W-1:0] b;
        logic [N*W-1:0] r;
        b = model_buf(din);
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = b[k*W +: W] + 32'(STAGES);
        return r;
    endfunction

    // One full transform, entered at a negedge with the DUT in IDLE; returns at the negedge where done shows.
    // in_mode/out_mode: 0 always, 1 alternate / 1,0,0 pattern, 2 random.
    task automatic run_xfer(input logic [N*W-1:0] din, input logic [N*W-1:0] expv,
                            input int in_mode, input int out_mode, input bit noisy, input bit abort);
        int  k;
        int  n;
        int  budget;
        logic vld;
        logic rdy;
        logic acc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("load_in_ready", in_ready, 1'b1);
        chk1("load_busy", busy, 1'b1);
        k = 0;
        budget = 0;
        while (k < N && budget < 200) begin
            vld = (in_mode == 0) ? 1'b1 : (in_mode == 1) ? 1'(budget % 2 == 0) : 1'($urandom % 2);
            in_valid = vld;
            in_data  = vld ? din[k*W +: W] : $urandom;
            acc = vld && in_ready;
            @(negedge clk);
            budget++;
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk32("load_count", 32'(k), 32'(N));
        chkw("step_in_loaded", step_in, model_buf(din));
        for (int c = 0; c < STAGES * (LAT + 1); c++) begin
            chk1("step_stage_number", stage_number[0], 1'((c / (LAT + 1)) != 0));
            chk1("step_out_valid", out_valid, 1'b0);
            chk1("step_in_ready", in_ready, 1'b0);
            if (abort && c == 1) begin
                rst_n = 1'b0;
                #1;
                chk1("abort_busy", busy, 1'b0);
                chk1("abort_stage", stage_number[0], 1'b0);
                chkw("abort_step_in", step_in, '0);
                chk1("abort_out_valid", out_valid, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (noisy) begin
                start    = (c == 1);
                in_valid = 1'b1;
                in_data  = 32'd999;
            end
            @(negedge clk);
        end
        n = 0;
        budget = 0;
        while (n < N && budget < 200) begin
            if (noisy) begin
                start    = 1'(budget % 2);
                in_valid = 1'b1;
                in_data  = 32'd999;
                chk1("drain_in_ready", in_ready, 1'b0);
            end
            rdy = (out_mode == 0) ? 1'b1 : (out_mode == 1) ? 1'(budget % 3 == 0) : 1'($urandom % 2);
            out_ready = rdy;
            chk1("drain_out_valid", out_valid, 1'b1);
            chk32("drain_out_data", out_data, expv[n*W +: W]);
            acc = rdy && out_valid;
            @(negedge clk);
            budget++;
            if (acc) n++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk32("drain_count", 32'(n), 32'(N));
        chk1("done_pulse", done, 1'b1);
        chk1("done_idle_busy", busy, 1'b0);
        chk1("done_no_extra_beat", out_valid, 1'b0);
    endtask

    task automatic idle_gap();
        @(negedge clk);
        chk1("done_one_cycle", done, 1'b0);
        chk1("idle_busy", busy, 1'b0);
    endtask

    typedef struct packed {
        logic [N*W-1:0] din;
        logic [N*W-1:0] exp_nat;
        logic [N*W-1:0] exp_rev;
    } vec_t;

    vec_t           vecs [4];
    logic [N*W-1:0] expv;
    logic [N*W-1:0] rdin;

    function automatic logic [N*W-1:0] pick(input vec_t v);
`ifdef FFT_SEQ_BITREV_EN
        return v.exp_rev;
`else
        return v.exp_nat;
`endif
    endfunction

    initial begin
        vecs[0] = '{din:     {32'd250, 32'd200, 32'd150, 32'd100},
                    exp_nat: {32'd252, 32'd202, 32'd152, 32'd102},
                    exp_rev: {32'd252, 32'd152, 32'd202, 32'd102}};
        vecs[1] = '{din:     {32'd4, 32'd3, 32'd2, 32'd1},
                    exp_nat: {32'd6, 32'd5, 32'd4, 32'd3},
                    exp_rev: {32'd6, 32'd4, 32'd5, 32'd3}};
        vecs[2] = '{din:     {32'h7FFFFFFF, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF},
                    exp_nat: {32'h80000001, 32'h2, 32'h0, 32'h1},
                    exp_rev: {32'h80000001, 32'h0, 32'h2, 32'h1}};
        vecs[3] = '{din:     {32'h12345678, 32'h5A5A5A5A, 32'h0, 32'hA5A5A5A5},
                    exp_nat: {32'h1234567A, 32'h5A5A5A5C, 32'h2, 32'hA5A5A5A7},
                    exp_rev: {32'h1234567A, 32'h2, 32'h5A5A5A5C, 32'hA5A5A5A7}};

        repeat (3) @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_stage_number", stage_number[0], 1'b0);
        chkw("rst_step_in", step_in, '0);
        chk32("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;

        // in_valid in IDLE is not consumed
        in_valid = 1'b1;
        in_data  = 32'd999;
        repeat (2) @(negedge clk);
        chk1("idle_in_ready", in_ready, 1'b0);
        chk1("idle_no_start", busy, 1'b0);
        in_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_xfer(vecs[i].din, pick(vecs[i]), 0, 0, 1'b0, 1'b0);
            idle_gap();
        end

        run_xfer(vecs[0].din, pick(vecs[0]), 1, 1, 1'b0, 1'b0);
        idle_gap();

        run_xfer(vecs[0].din, pick(vecs[0]), 0, 0, 1'b1, 1'b0);
        idle_gap();

        // start in the done cycle launches the next transform immediately
        run_xfer(vecs[1].din, pick(vecs[1]), 0, 0, 1'b0, 1'b0);
        run_xfer(vecs[3].din, pick(vecs[3]), 0, 1, 1'b0, 1'b0);
        idle_gap();

        run_xfer(vecs[0].din, pick(vecs[0]), 0, 0, 1'b0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk1("post_abort_done", done, 1'b0);
            chk1("post_abort_busy", busy, 1'b0);
        end
        run_xfer(vecs[1].din, pick(vecs[1]), 0, 0, 1'b0, 1'b0);
        idle_gap();

        for (int r = 0; r < 12; r++) begin
            rdin = {$urandom, $urandom, $urandom, $urandom};
            expv = model_out(rdin);
            run_xfer(rdin, expv, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom % 2), 1'b0);
            if ($urandom % 2 == 0) idle_gap();
        end
        idle_gap();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Sequencer that owns the sample buffer for one `FFT_step` instance and steps it through every butterfly stage of a SAMPLES-point transform. It collects SAMPLES words over a valid/ready input stream and presents the whole buffer plus `stage_number` to the step datapath. It captures each stage result back into the buffer, then streams the finished transform out. It sits between the sample source (ADC/front-end FIFO) and the display/magnitude path.

## Interface
- `SAMPLES`, 4: transform length; power of two, ≥2.
- `WIDTH`, 32: bits per sample word.
- `STEP_LATENCY`, 1: cycles from `step_in`/`stage_number` stable to `step_out` valid (0 = combinational step).
- `clk`  in  1  single clock; all state rises on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `in_data`  in  WIDTH  input sample.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  sequencer accepts a sample this cycle.
- `step_in`  out  [WIDTH-1:0] x SAMPLES  buffer driven to the step's `sampleInputs`.
- `stage_number`  out  max(1,$clog2(STAGES))  stage index driven to the step; STAGES = $clog2(SAMPLES).
- `step_out`  in  [WIDTH-1:0] x SAMPLES  step result.
- `out_data`  out  WIDTH  output sample.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts output.
- `busy`  out  1  high in any state but IDLE.
- `done`  out  1  one-cycle pulse after the last output beat.

## Operation
- FSM states: IDLE, LOAD, STEP, DRAIN.
- IDLE:
  - `start` → LOAD.
  - Clear the load index, stage counter and wait counter.
- LOAD:
  - `in_ready`=1.
  - On each `in_valid&&in_ready`, write `in_data` to buffer[addr(idx)], then idx++.
  - On the SAMPLES-th beat → STEP with stage=0 and wait=0.
- STEP:
  - `step_in`=buffer and `stage_number`=stage are held constant for the whole stage.
  - The wait counter runs 0..STEP_LATENCY.
  - On the cycle where wait==STEP_LATENCY, buffer ← `step_out` (all words, one edge), wait ← 0, stage++.
  - If stage==STAGES-1 at that edge → DRAIN with idx=0.
- DRAIN:
  - `out_valid`=1 and `out_data`=buffer[idx].
  - On `out_valid&&out_ready`, idx++.
  - On the last beat → IDLE and `done` pulses for exactly one cycle (the first IDLE cycle).
- `in_ready` is 0 outside LOAD. `in_valid` outside LOAD is ignored and the sample is not consumed.
- `start` is ignored outside IDLE. `start` asserted in the same cycle that `done` pulses starts a new transform.
- Output order is buffer index order, 0..SAMPLES-1.
- No arithmetic is done here. Words pass through bit-exact, with no width growth or truncation.

## Timing
- Reset values:
  - state=IDLE; `in_ready`, `out_valid`, `busy` and `done` = 0.
  - `stage_number`=0, `out_data`=0, buffer all zero, so `step_in`=0.
- LOAD with `in_valid` held high takes SAMPLES cycles.
- STEP takes STAGES×(STEP_LATENCY+1) cycles. SAMPLES=4, STEP_LATENCY=1 gives 4 cycles.
- DRAIN takes SAMPLES cycles with `out_ready` high; each cycle `out_ready` is low adds one cycle.
- `out_data`/`out_valid` stay stable while `out_valid&&!out_ready` (standard valid/ready hold).
- Reset mid-operation: `rst_n` low returns to IDLE immediately and asynchronously, clears all state, and drops any partial transform. No `done` is produced.
- SAMPLES=2: STAGES=1 and `stage_number` is 1 bit, always 0.

## Configuration
- `FFT_SEQ_BITREV_EN` defined: the load address is the bit-reversed idx ($clog2(SAMPLES) bits). Input reorder for decimation-in-time is done here, so the step never reorders.
- Not defined: the load address is idx (natural order). The reorder must happen upstream or inside the step.
- Drain order is natural index in both builds.

## Test plan
Unless stated otherwise, the bench uses a stub step that returns each `step_in` word +1 after STEP_LATENCY=1 cycles, with SAMPLES=4 and WIDTH=32.
- Reset: hold `rst_n`=0 for 3 cycles → `in_ready`=`out_valid`=`busy`=`done`=0, `stage_number`=0, `step_in` all 0.
- Basic, macro off: `start`, load 100,150,200,250 back-to-back → `stage_number` reads 0,0,1,1 across 4 STEP cycles → outputs 102,152,202,252 → `done` for one cycle.
- Basic, `FFT_SEQ_BITREV_EN` on: same stimulus → buffer before STEP holds 100,200,150,250 → outputs 102,202,152,252.
- Backpressure: drive `in_valid` in alternate cycles and toggle `out_ready` 1,0,0,1… → output data and order match the basic case, and `out_data` is held stable while stalled.
- Ignored controls: pulse `start` during STEP and DRAIN, and hold `in_valid`=1 with `in_data`=999 in DRAIN → no restart, 999 never appears, exactly 4 outputs.
- Reset mid-run: drop `rst_n` in cycle 2 of STEP, release, start a new transform with 1,2,3,4 → outputs 3,4,5,6 with no residue from the aborted run.
